// File: rtl/segment_scan_driver.sv
// Multiplexed common-anode 7-segment driver: snapshots the digit bus once per
// frame, scans digits with a blank gap, and decodes hex/BCD with zero blanking.
module segment_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzs_en,
    output logic [7:0]              segment_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lzs;
    logic                    load_pending;

    logic                    tick;
    logic                    wrap;
    logic                    load;
    logic [3:0]              cur_val;
    logic                    cur_dp;
    logic                    cur_sup;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   active_sel;
    logic [7:0]              dec;
    logic [7:0]              next_seg;

    function automatic logic [7:0] decode(input logic [3:0] v);
        logic [7:0] r;
        case (v)
            4'h0:    r = 8'hC0;
            4'h1:    r = 8'hF9;
            4'h2:    r = 8'hA4;
            4'h3:    r = 8'hB0;
            4'h4:    r = 8'h99;
            4'h5:    r = 8'h92;
            4'h6:    r = 8'h82;
            4'h7:    r = 8'hF8;
            4'h8:    r = 8'h80;
            4'h9:    r = 8'h90;
            4'hA:    r = 8'h88;
            4'hB:    r = 8'h83;
            4'hC:    r = 8'hC6;
            4'hD:    r = 8'hA1;
            4'hE:    r = 8'h86;
            default: r = 8'h8E;
        endcase
        if (HEX_MODE == 0 && v > 4'd9) begin
            r = 8'hBF;
        end
        return r;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);
    // The first edge out of reset also loads, so frame 0 shows live inputs.
    assign load = wrap || load_pending;

    // Walk from the top digit down so zero_run means "this digit and all above are zero".
    always_comb begin
        cur_val    = 4'd0;
        cur_dp     = 1'b0;
        cur_sup    = 1'b0;
        zero_run   = 1'b1;
        active_sel = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_digits[4*i +: 4] == 4'd0);
            if (idx == IW'(i)) begin
                cur_val       = sh_digits[4*i +: 4];
                cur_dp        = sh_dp[i];
                cur_sup       = sh_lzs && (i != 0) && zero_run;
                active_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        dec      = decode(cur_val);
        next_seg = {~cur_dp, (cur_sup ? 7'h7F : dec[6:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            sh_digits    <= '0;
            sh_dp        <= '0;
            sh_lzs       <= 1'b0;
            load_pending <= 1'b1;
            segment_code <= 8'hFF;
            digit_sel    <= '1;
            frame_start  <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + 1'b1;
            load_pending <= 1'b0;
            frame_start  <= wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                sh_digits <= digits;
                sh_dp     <= dp_in;
                sh_lzs    <= lzs_en;
            end
            // Segments track the index even in the gap, so they settle before the anode turns on.
            segment_code <= next_seg;
            digit_sel    <= (cnt < BLANK_END) ? '1 : active_sel;
        end
    end

endmodule

// File: tb/tb_segment_scan_driver.sv
// Bench for segment_scan_driver: two instances (dash and hex decode) share
// stimulus and are compared every cycle against a cycle-count reference model.
module tb_segment_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int W   = 21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        lzs_en = 1'b0;
    logic [7:0]  seg_dash, seg_hex;
    logic [3:0]  sel_dash, sel_hex;
    logic        fs_dash, fs_hex;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    int          t = 0;
    logic [15:0] s_d = 16'h0000;
    logic [3:0]  s_dp = 4'b0000;
    logic        s_lz = 1'b0;

    logic [7:0] dec_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] hex_tab [0:5] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    segment_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(0)) u_dash (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .lzs_en(lzs_en),
        .segment_code(seg_dash), .digit_sel(sel_dash), .frame_start(fs_dash)
    );

    segment_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(1)) u_hex (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .lzs_en(lzs_en),
        .segment_code(seg_hex), .digit_sel(sel_hex), .frame_start(fs_hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] dp,
                                           input logic lz, input int pos, input bit hex);
        logic [15:0] upper;
        logic [3:0]  v;
        logic [7:0]  full;
        upper = d >> (4 * pos);
        v = upper[3:0];
        if (v < 4'd10)  full = dec_tab[v];
        else if (hex)   full = hex_tab[v - 4'd10];
        else            full = 8'hBF;
        if (lz && pos > 0 && upper == 16'h0000) full = 8'hFF;
        full[7] = ~dp[pos];
        return full;
    endfunction

    // Reference: edge t (counted from release) shows slot ((t-1)/DIV)%ND,
    // phase (t-1)%DIV; frames are ND*DIV edges and load on edge 1 and every frame boundary.
    task automatic model_edge();
        int          ph;
        int          pos;
        logic [3:0]  e_sel;
        logic        e_fs;
        if (rst) begin
            t = 0;
            s_d = 16'h0000;
            s_dp = 4'b0000;
            s_lz = 1'b0;
            exp_q.push_back({8'hFF, 8'hFF, 4'hF, 1'b0});
        end else begin
            t++;
            ph  = (t - 1) % DIV;
            pos = ((t - 1) / DIV) % ND;
            e_sel = (ph < BLK) ? 4'hF : ~(4'b0001 << pos);
            e_fs  = ((t % (ND * DIV)) == 0);
            exp_q.push_back({ref_seg(s_d, s_dp, s_lz, pos, 1'b0),
                             ref_seg(s_d, s_dp, s_lz, pos, 1'b1), e_sel, e_fs});
            if (t == 1 || (t % (ND * DIV)) == 0) begin
                s_d = digits;
                s_dp = dp_in;
                s_lz = lzs_en;
            end
        end
    endtask

    task automatic step();
        logic [W-1:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e = exp_q.pop_front();
        check("seg_dash", {24'h0, seg_dash}, {24'h0, e[20:13]});
        check("seg_hex",  {24'h0, seg_hex},  {24'h0, e[12:5]});
        check("sel_dash", {28'h0, sel_dash}, {28'h0, e[4:1]});
        check("sel_hex",  {28'h0, sel_hex},  {28'h0, e[4:1]});
        check("fs_dash",  {31'h0, fs_dash},  {31'h0, e[0]});
        check("fs_hex",   {31'h0, fs_hex},   {31'h0, e[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < 4; k++) begin
            digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        dp_in  = 4'($urandom_range(0, 15));
        lzs_en = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        digits = 16'h1234;
        run(36);
        // Change the bus partway through a frame; the model keeps the old snapshot.
        for (int i = 0; i < 16 && (t % 16) != 8; i++) step();
        digits = 16'h5678;
        run(24);
        digits = 16'h0070;
        dp_in  = 4'b0010;
        lzs_en = 1'b1;
        run(32);
        digits = 16'h0000;
        run(32);
        digits = 16'hAF09;
        dp_in  = 4'b0000;
        lzs_en = 1'b0;
        run(32);
        for (int i = 0; i < 16 && (t % 16) != 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(40);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) rand_inputs();
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        run(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
